// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Round-robin arbiter that shares one register-access bus between N_REQ
//   requesters. Each grant produces exactly one single-cycle bus strobe,
//   waits RD_LAT cycles for read data when reading, and then returns a
//   one-cycle, one-hot acknowledge to the granted requester.
//
// Handshake: a requester raises req[i] with req_we/req_addr/req_wdata
//   stable and keeps it high until it sees ack[i]. The arbiter latches the
//   fields at grant, so anything that changes later is ignored. ack[i] is a
//   single-cycle pulse. A requester that keeps req high after its ack
//   re-enters arbitration behind the others.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   req        per-requester request
//   req_we     per-requester write(1)/read(0)
//   req_addr   flattened addresses, slice i = requester i
//   req_wdata  flattened write data, slice i = requester i
//   ack        one-hot completion pulse
//   ack_rdata  read data, valid in the ack cycle of a read
//   grant_id   index of the current or last grant
//   busy       high from grant until ack inclusive
//   bus_wr_en  register-bus write strobe
//   bus_rd_en  register-bus read strobe
//   bus_addr   register-bus address
//   bus_wdata  register-bus write data
//   bus_rdata  register-bus read data
//   dbg_state  current FSM state (IDLE=0, ISSUE=1, RD_WAIT=2, DONE=3)
module reg_bus_arbiter #(
  parameter int N_REQ  = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       ack_rdata,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic                bus_wr_en,
  output logic                bus_rd_en,
  output logic [AW-1:0]       bus_addr,
  output logic [DW-1:0]       bus_wdata,
  input  logic [DW-1:0]       bus_rdata,
  output logic [1:0]          dbg_state
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_last_grant;
  logic [GW-1:0]     r_grant_id;
  logic              r_we;
  logic              r_busy;
  logic              r_wr_en;
  logic              r_rd_en;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW-1:0]     r_ack_rdata;
  logic [N_REQ-1:0]  r_ack;
  logic [CW-1:0]     r_cnt;

  // Round robin: prefer the lowest requester above last_grant, otherwise
  // wrap around to the lowest requester overall.
  logic [N_REQ-1:0]  w_req_hi;
  logic [GW-1:0]     w_pick_hi;
  logic [GW-1:0]     w_pick_lo;
  logic [GW-1:0]     w_pick;
  logic              w_any;

  always_comb begin
    w_req_hi  = '0;
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_req_hi[i] = req[i] && (GW'(i) > r_last_grant);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_req_hi[i]) w_pick_hi = GW'(i);
      if (req[i])      w_pick_lo = GW'(i);
    end
    w_any  = |req;
    w_pick = (|w_req_hi) ? w_pick_hi : w_pick_lo;
  end

  // Fields of the requester being picked this cycle.
  logic              w_sel_we;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == w_pick) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = r_we ? S_DONE : S_RD_WAIT;
      S_RD_WAIT: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Strobes are
  // computed at the grant edge so they are high exactly during ISSUE.
  logic              w_grant;
  logic              w_capture;
  logic              w_wr_en_nxt;
  logic              w_rd_en_nxt;
  logic              w_busy_nxt;
  logic [N_REQ-1:0]  w_ack_nxt;
  logic [CW-1:0]     w_cnt_nxt;

  always_comb begin
    w_grant     = (r_state == S_IDLE) && w_any;
    w_capture   = (r_state == S_RD_WAIT) && (r_cnt == '0);
    w_wr_en_nxt = w_grant && w_sel_we;
    w_rd_en_nxt = w_grant && !w_sel_we;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_ack_nxt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ack_nxt[i] = (w_state_nxt == S_DONE) && (GW'(i) == r_grant_id);
    end
    w_cnt_nxt = r_cnt;
    if (r_state == S_ISSUE)                      w_cnt_nxt = CW'(RD_LAT - 1);
    else if (r_state == S_RD_WAIT && r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GW'(N_REQ - 1);
      r_grant_id   <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack_rdata  <= '0;
      r_ack        <= '0;
      r_cnt        <= '0;
    end else begin
      r_wr_en <= w_wr_en_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_grant_id <= w_pick;
        r_we       <= w_sel_we;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
      end
      // ack_rdata is only updated by a read capture, never cleared by a write.
      if (w_capture) r_ack_rdata <= bus_rdata;
      if (r_state == S_DONE) r_last_grant <= r_grant_id;
    end
  end

  assign ack       = r_ack;
  assign ack_rdata = r_ack_rdata;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign bus_wr_en = r_wr_en;
  assign bus_rd_en = r_rd_en;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign dbg_state = r_state;

endmodule
